fir_filter_tdm: RTL and testbench

- Parametrised, time-multiplexed, N-tap signed FIR filter with one shared multiply-accumulate unit.
- Successor to the fixed 8-tap parallel filter. Adds run-time programmable coefficients, valid/ready streaming on input and output, rounding, output saturation and a synchronous flush.
- Sits in the DSP datapath between the sample source and downstream consumers.

---
 rtl/fir_filter_tdm.sv | 151 +++++++++++++++
 tb/tb_fir_filter_tdm.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_tdm.sv
// Time-multiplexed N-tap signed FIR filter with one shared MAC,
// programmable coefficients, rounding, saturation and flush.
module fir_filter_tdm #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int ACC_W  = 40,
  parameter int SHIFT  = 8,
  parameter int ROUND  = 1,
  localparam int AW    = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y_out,
  output logic              out_sat,
  input  logic              coef_wr,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              coef_err
);

  localparam int PW = DATA_W + COEF_W;
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam int EW = ACC_W - DATA_W + 2;

  localparam logic [ACC_W:0] RND =
    (ROUND != 0 && SHIFT > 0) ? ((ACC_W+1)'(1) << RS) : '0;
  localparam logic signed [ACC_W:0] YMAX =
    {{EW{1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] YMIN =
    {{EW{1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_nx;

  logic signed [DATA_W-1:0] d    [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W:0]    rsum;
  logic signed [ACC_W:0]    scaled;
  logic [DATA_W-1:0]        y_nx;
  logic                     sat_nx;
  logic [AW-1:0]            idx;
  logic                     accept;
  logic                     last;
  logic                     hs;
  logic                     addr_ok;

  assign accept  = in_valid && in_ready;
  assign last    = (idx == AW'(TAPS - 1));
  assign hs      = out_valid && out_ready;
  assign addr_ok = (int'(coef_addr) < TAPS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (accept) state_nx = MAC;
        MAC:     if (last)   state_nx = OUT;
        OUT:     if (hs)     state_nx = IDLE;
        default:             state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

  // Full-precision product sign-extended into the accumulator.
  always_comb begin
    prod   = d[idx] * coef[idx];
    sum    = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
    rsum   = {sum[ACC_W-1], sum} + $signed(RND);
    scaled = rsum >>> SHIFT;
    y_nx   = scaled[DATA_W-1:0];
    sat_nx = 1'b0;
    if (scaled > YMAX) begin
      y_nx   = YMAX[DATA_W-1:0];
      sat_nx = 1'b1;
    end else if (scaled < YMIN) begin
      y_nx   = YMIN[DATA_W-1:0];
      sat_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < TAPS; k++) d[k] <= '0;
      acc       <= '0;
      idx       <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
    end else if (flush) begin
      for (int k = 0; k < TAPS; k++) d[k] <= '0;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      if (accept) begin
        for (int k = TAPS - 1; k > 0; k--) d[k] <= d[k-1];
        d[0] <= x_in;
        acc  <= '0;
        idx  <= '0;
      end
      if (state == MAC) begin
        acc <= sum;
        idx <= idx + AW'(1);
        if (last) begin
          y_out     <= y_nx;
          out_sat   <= sat_nx;
          out_valid <= 1'b1;
        end
      end
      if (hs) out_valid <= 1'b0;
    end
  end

  // Writes land only while idle; a write alongside flush is dropped silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= '0;
      coef_err <= 1'b0;
    end else begin
      coef_err <= 1'b0;
      if (coef_wr && !flush) begin
        if (state == IDLE && addr_ok) coef[coef_addr] <= coef_data;
        else                          coef_err        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_filter_tdm.sv
// Scoreboard bench for fir_filter_tdm: directed vectors,
// monitor pops expected outputs on every output handshake.
module tb_fir_filter_tdm;

  localparam int T = 8;

  typedef struct {
    logic signed [15:0] y;
    logic               s;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] x_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] y_out;
  logic               out_sat;
  logic               coef_wr;
  logic [2:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic               coef_err;

  logic               t_in_valid;
  logic               t_in_ready;
  logic signed [15:0] t_x;
  logic               t_out_valid;
  logic               t_out_ready;
  logic signed [15:0] t_y;
  logic               t_sat;
  logic               t_coef_wr;
  logic [2:0]         t_coef_addr;
  logic signed [15:0] t_coef_data;
  logic               t_coef_err;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   lat   = 0;
  bit   armed = 1'b0;

  int c2 [T] = '{50, 100, 150, 200, 200, 150, 100, 50};
  int c3 [T] = '{1, 0, 0, 0, 0, 0, 0, 0};
  int cmx[T] = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
  int c1 [T] = '{1, 1, 1, 1, 1, 1, 1, 1};
  int yneg[T] = '{32767, 32767, 32767, -512, -32768, -32768, -32768, -32768};
  int sneg[T] = '{1, 1, 1, 0, 1, 1, 1, 1};
  int ymix[T] = '{-895, -766, -637, -508, -379, -250, -121, 8};

  fir_filter_tdm dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .y_out(y_out), .out_sat(out_sat),
    .coef_wr(coef_wr), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_err(coef_err)
  );

  fir_filter_tdm #(.TAPS(6), .ROUND(0)) u_trunc (
    .clk(clk), .reset_n(reset_n), .flush(1'b0),
    .in_valid(t_in_valid), .in_ready(t_in_ready), .x_in(t_x),
    .out_valid(t_out_valid), .out_ready(t_out_ready),
    .y_out(t_y), .out_sat(t_sat),
    .coef_wr(t_coef_wr), .coef_addr(t_coef_addr),
    .coef_data(t_coef_data), .coef_err(t_coef_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      armed = 1'b0;
    end else begin
      if (armed) lat++;
      if (armed && out_valid) begin
        chk("latency", lat, T);
        armed = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected out_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("y_out", y_out, e.y);
          chk("out_sat", out_sat, e.s);
        end
      end
      if (in_valid && in_ready) begin
        armed = 1'b1;
        lat   = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int y, input bit s,
                      input bit push);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready timeout", 0, 1);
    x_in     = 16'(x);
    in_valid = 1'b1;
    if (push) q.push_back('{16'(y), s});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 300) begin
      tick();
      n++;
    end
    if (q.size() != 0 || !in_ready) chk("drain timeout", 0, 1);
  endtask

  task automatic load(input int c[T]);
    for (int i = 0; i < T; i++) begin
      coef_wr   = 1'b1;
      coef_addr = 3'(i);
      coef_data = 16'(c[i]);
      tick();
    end
    coef_wr = 1'b0;
  endtask

  initial begin
    int n;
    reset_n     = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    x_in        = '0;
    out_ready   = 1'b1;
    coef_wr     = 1'b0;
    coef_addr   = '0;
    coef_data   = '0;
    t_in_valid  = 1'b0;
    t_x         = '0;
    t_out_ready = 1'b1;
    t_coef_wr   = 1'b0;
    t_coef_addr = '0;
    t_coef_data = '0;
    repeat (2) tick();
    chk("rst y_out", y_out, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_sat", out_sat, 0);
    chk("rst coef_err", coef_err, 0);
    reset_n = 1'b1;
    tick();

    // Reset mid-MAC wipes coefficients.
    load(c2);
    send(256, 0, 0, 0);
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk("midrst in_ready", in_ready, 1);
    chk("midrst out_valid", out_valid, 0);
    tick();
    reset_n = 1'b1;
    q.delete();
    chk("midrst y_out", y_out, 0);
    send(256, 0, 0, 1);
    for (int i = 1; i < T; i++) send(0, 0, 0, 1);
    drain();

    load(c2);
    send(256, c2[0], 0, 1);
    for (int i = 1; i < T; i++) send(0, c2[i], 0, 1);
    send(0, 0, 0, 1);
    drain();

    load(c3);
    send(128, 1, 0, 1);
    send(-129, -1, 0, 1);
    drain();

    t_coef_wr   = 1'b1;
    t_coef_addr = 3'd0;
    t_coef_data = 16'sd1;
    tick();
    chk("trunc coef_err ok", t_coef_err, 0);
    t_coef_addr = 3'd7;
    t_coef_data = 16'sd5;
    tick();
    t_coef_wr = 1'b0;
    chk("trunc coef_err addr", t_coef_err, 1);
    tick();
    chk("trunc coef_err pulse", t_coef_err, 0);
    t_x        = 16'sd128;
    t_in_valid = 1'b1;
    tick();
    t_in_valid = 1'b0;
    n = 0;
    while (!t_out_valid && n < 30) begin
      tick();
      n++;
    end
    chk("trunc out_valid", t_out_valid, 1);
    chk("trunc y_out", t_y, 0);

    load(cmx);
    for (int i = 0; i < T; i++) send(32767, 32767, 1, 1);
    for (int i = 0; i < T; i++) send(-32768, yneg[i], sneg[i], 1);
    drain();
    load(c1);
    for (int i = 0; i < T; i++) send(256, ymix[i], 0, 1);
    drain();

    // Backpressure: held output, stalled input.
    out_ready = 1'b0;
    send(256, 8, 0, 1);
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    x_in     = 16'sd1000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp y_out", y_out, 8);
      chk("bp out_valid", out_valid, 1);
      chk("bp in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    send(0, 7, 0, 1);
    send(0, 6, 0, 1);
    coef_wr   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'sd999;
    tick();
    coef_wr = 1'b0;
    chk("mac coef_err", coef_err, 1);
    tick();
    chk("mac coef_err pulse", coef_err, 0);
    send(256, 6, 0, 1);
    drain();

    // Flush mid-MAC discards the sample, keeps coefficients.
    load(c2);
    send(256, 0, 0, 0);
    repeat (3) tick();
    flush     = 1'b1;
    coef_wr   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'sd7;
    tick();
    flush   = 1'b0;
    coef_wr = 1'b0;
    chk("flush coef_err", coef_err, 0);
    chk("flush in_ready", in_ready, 1);
    repeat (12) tick();
    chk("flush out_valid", out_valid, 0);
    send(256, c2[0], 0, 1);
    for (int i = 1; i < T; i++) send(0, c2[i], 0, 1);
    drain();

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
